// File: rtl/p2s_arbiter.sv
// Round-robin arbiter sharing one parallel-to-serial converter among M word sources.
// Define P2S_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module p2s_arbiter #(
    parameter int N         = 8,
    parameter int M         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [M-1:0]           req_valid,
    input  logic [M*N-1:0]         req_data,
    input  logic [M-1:0]           req_last,
    output logic [M-1:0]           req_ready,
    output logic                   p_valid,
    output logic [N-1:0]           p_data,
    input  logic                   p_ready,
    output logic                   busy,
    output logic [$clog2(M)-1:0]   grant_id
);

    localparam int GW = $clog2(M);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [GW-1:0]   winner;
    logic            accept;
    logic            burst_end;

    always_comb begin
`ifdef P2S_ARB_FIXED_PRIO_EN
        winner = GW'(M - 1);
        for (int k = M - 1; k >= 0; k--) begin
            if (req_valid[k]) winner = GW'(k);
        end
`else
        // Walk offsets from farthest to nearest so the nearest requester after grant_q wins.
        winner = grant_q;
        for (int k = M; k >= 1; k--) begin
            int idx;
            idx = (int'(grant_q) + k) % M;
            if (req_valid[idx]) winner = GW'(idx);
        end
`endif
    end

    assign busy      = (state_q == GRANT);
    assign grant_id  = grant_q;
    assign p_data    = req_data[int'(grant_q)*N +: N];
    assign p_valid   = busy & req_valid[grant_q];
    assign accept    = p_valid & p_ready;
    assign burst_end = req_last[grant_q] | (beat_q == BW'(MAX_BURST - 1));

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_ready
            assign req_ready[gi] = busy & p_ready & (grant_q == GW'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = GRANT;
                    grant_d = winner;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    if (burst_end) state_d = IDLE;
                    else           beat_d  = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= GW'(M - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_p2s_arbiter.sv
// Randomized, scoreboard-checked bench for p2s_arbiter with a cycle-level spec model
// and a behavioural serializer used as the downstream sink in the backpressure test.
module tb_p2s_arbiter;

    localparam int N     = 8;
    localparam int M     = 4;
    localparam int MB    = 4;
    localparam int GW    = 2;
    localparam int DEPTH = 64;

    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    logic [M-1:0]    req_valid = '0;
    logic [M*N-1:0]  req_data  = '0;
    logic [M-1:0]    req_last  = '0;
    logic [M-1:0]    req_ready;
    logic            p_valid;
    logic [N-1:0]    p_data;
    logic            p_ready = 1'b0;
    logic            busy;
    logic [GW-1:0]   grant_id;

    always #5 clk = ~clk;

    p2s_arbiter #(.N(N), .M(M), .MAX_BURST(MB)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .p_valid(p_valid), .p_data(p_data),
        .p_ready(p_ready), .busy(busy), .grant_id(grant_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Per-requester word FIFOs: bit N is the last flag.
    logic [N:0]     mem [M][DEPTH];
    int             head [M];
    int             tail [M];
    int             gap_cnt [M];

    // Spec-level model: who holds the grant (-1 = nobody) and words taken so far.
    int             holder, last_gid, taken;
    int             grants[$];
    int             blens[$];
    logic [N-1:0]   acc_words[$];
    bit             exp_acc;

    int             pr_mode;
    bit             pr_const;
    int             ser_cnt;
    logic [N-1:0]   ser_sh;
    bit             sbits[$];
    int             gap_req, gap_len;
    bit             rand_gaps;

    function automatic int pick(logic [M-1:0] v, int last);
`ifdef P2S_ARB_FIXED_PRIO_EN
        for (int i = 0; i < M; i++) if (v[i]) return i;
`else
        for (int off = 1; off <= M; off++) if (v[(last + off) % M]) return (last + off) % M;
`endif
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < M; i++) if (head[i] < tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        holder = -1; last_gid = M - 1; taken = 0; ser_cnt = 0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < M; i++) begin head[i] = 0; tail[i] = 0; gap_cnt[i] = 0; end
        grants.delete(); blens.delete(); acc_words.delete(); sbits.delete();
        gap_req = 0; gap_len = 0; rand_gaps = 1'b0; pr_mode = 0; pr_const = 1'b1;
        model_reset();
    endtask

    task automatic push_word(int r, logic [N-1:0] d, bit l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < M; i++) begin
            if (head[i] < tail[i] && gap_cnt[i] == 0) begin
                req_valid[i]       = 1'b1;
                req_data[i*N +: N] = mem[i][head[i]][N-1:0];
                req_last[i]        = mem[i][head[i]][N];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*N +: N] = N'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
        case (pr_mode)
            0:       p_ready = pr_const;
            1:       p_ready = 1'($urandom_range(0, 1));
            default: p_ready = (ser_cnt == 0);
        endcase
    endtask

    task automatic do_reset();
        clear_all();
        rstn = 1'b0;
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive();
    endtask

    // One clock: compare outputs against the model at negedge, then advance the model.
    task automatic cycle();
        bit           e_busy, e_pv;
        int           e_gid;
        logic [M-1:0] e_rdy;
        logic [N:0]   w;
        @(negedge clk);
        e_busy = (holder >= 0);
        e_gid  = e_busy ? holder : last_gid;
        e_pv   = e_busy && req_valid[holder];
        e_rdy  = (e_busy && p_ready) ? (M'(1) << holder) : '0;
        n_cmp += 4;
        if (busy !== e_busy) begin n_bad++; $display("FAIL busy: got %0b want %0b", busy, e_busy); end
        if (grant_id !== GW'(e_gid)) begin n_bad++; $display("FAIL grant_id: got %0d want %0d", grant_id, e_gid); end
        if (p_valid !== e_pv) begin n_bad++; $display("FAIL p_valid: got %0b want %0b", p_valid, e_pv); end
        if (req_ready !== e_rdy) begin n_bad++; $display("FAIL req_ready: got %b want %b", req_ready, e_rdy); end
        if (e_pv) begin
            n_cmp++;
            if (p_data !== mem[holder][head[holder]][N-1:0]) begin
                n_bad++;
                $display("FAIL p_data: got %02h want %02h", p_data, mem[holder][head[holder]][N-1:0]);
            end
        end
        exp_acc = e_pv && p_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < M; i++) if (gap_cnt[i] > 0) gap_cnt[i]--;
        if (ser_cnt > 0) begin
            sbits.push_back(ser_sh[0]);
            ser_sh = ser_sh >> 1;
            ser_cnt--;
        end
        if (holder < 0) begin
            if (|req_valid) begin
                holder = pick(req_valid, last_gid);
                last_gid = holder;
                taken = 0;
                grants.push_back(holder);
            end
        end else if (exp_acc) begin
            w = mem[holder][head[holder]];
            head[holder]++;
            taken++;
            acc_words.push_back(w[N-1:0]);
            $display("beat req=%0d data=%02h last=%0b n=%0d", holder, w[N-1:0], w[N], taken);
            if (pr_mode == 2) begin ser_sh = w[N-1:0]; ser_cnt = N; end
            if (holder == gap_req && taken == 1 && gap_len > 0) begin
                gap_cnt[holder] = gap_len;
                gap_len = 0;
            end
            if (w[N] || taken == MB) begin
                blens.push_back(taken);
                holder = -1;
            end
        end
        if (rand_gaps) begin
            for (int i = 0; i < M; i++)
                if (gap_cnt[i] == 0 && $urandom_range(0, 15) == 0) gap_cnt[i] = $urandom_range(1, 3);
        end
        drive();
    endtask

    task automatic run_until_idle(int budget, string name);
        int c = 0;
        while ((holder >= 0 || pending() || ser_cnt > 0) && c < budget) begin
            cycle();
            c++;
        end
        cycle();
        n_cmp++;
        if (c >= budget) begin n_bad++; $display("FAIL %s_timeout: got %0d cycles want < %0d", name, c, budget); end
    endtask

    task automatic test_reset();
        clear_all();
        rstn = 1'b0;
        drive();
        req_valid = '1;
        @(posedge clk);
        #1;
        n_cmp += 5;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        if (p_valid !== 1'b0) begin n_bad++; $display("FAIL rst_p_valid: got %0b want 0", p_valid); end
        if (req_ready !== '0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
        if (grant_id !== GW'(M - 1)) begin n_bad++; $display("FAIL rst_grant_id: got %0d want %0d", grant_id, M - 1); end
        if (p_data !== req_data[(M-1)*N +: N]) begin
            n_bad++;
            $display("FAIL rst_p_data: got %02h want %02h", p_data, req_data[(M-1)*N +: N]);
        end
    endtask

    task automatic test_single();
        do_reset();
        push_word(2, 8'hA5, 1'b1);
        drive();
        run_until_idle(20, "single");
        n_cmp += 2;
        if (grants.size() != 1 || grants[0] != 2) begin
            n_bad++; $display("FAIL single_grant: got n=%0d first=%0d want n=1 first=2", grants.size(), grants.size() > 0 ? grants[0] : -1);
        end
        if (acc_words.size() != 1 || acc_words[0] !== 8'hA5) begin
            n_bad++; $display("FAIL single_word: got n=%0d want one A5", acc_words.size());
        end
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        for (int r = 0; r < M; r++)
            for (int k = 0; k < 3; k++) push_word(r, N'(r * 16 + k), 1'b1);
        drive();
        run_until_idle(200, "rr");
        n_cmp++;
        if (grants.size() != 12) begin n_bad++; $display("FAIL rr_count: got %0d want 12", grants.size()); end
        for (int k = 0; k < grants.size() && k < 12; k++) begin
`ifdef P2S_ARB_FIXED_PRIO_EN
            e = k / 3;
`else
            e = k % M;
`endif
            n_cmp++;
            if (grants[k] != e) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, grants[k], e); end
        end
    endtask

    task automatic test_burst_cap();
        do_reset();
        for (int k = 0; k < 6; k++) push_word(1, N'(8'h10 + k), k == 5);
        drive();
        run_until_idle(100, "cap");
        n_cmp += 2;
        if (blens.size() != 2 || blens[0] != 4 || blens[1] != 2) begin
            n_bad++; $display("FAIL cap_lens: got n=%0d first=%0d want 4 then 2", blens.size(), blens.size() > 0 ? blens[0] : -1);
        end
        if (grants.size() != 2 || grants[0] != 1 || grants[1] != 1) begin
            n_bad++; $display("FAIL cap_grants: got n=%0d want two grants to 1", grants.size());
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] wv[2];
        do_reset();
        pr_mode = 2;
        push_word(0, 8'h81, 1'b1);
        push_word(3, 8'h3C, 1'b1);
        drive();
        run_until_idle(200, "bp");
        wv[0] = 8'h81; wv[1] = 8'h3C;
        n_cmp++;
        if (sbits.size() != 2 * N) begin n_bad++; $display("FAIL bp_bitcount: got %0d want %0d", sbits.size(), 2 * N); end
        for (int k = 0; k < sbits.size() && k < 2 * N; k++) begin
            n_cmp++;
            if (sbits[k] != wv[k / N][k % N]) begin
                n_bad++; $display("FAIL bp_bit[%0d]: got %0b want %0b", k, sbits[k], wv[k / N][k % N]);
            end
        end
        n_cmp++;
        if (grants.size() != 2 || grants[0] != 0 || grants[1] != 3) begin
            n_bad++; $display("FAIL bp_grants: got n=%0d want 0 then 3", grants.size());
        end
    endtask

    task automatic test_valid_gap();
        do_reset();
        for (int k = 0; k < 3; k++) push_word(0, N'(8'h50 + k), k == 2);
        push_word(1, 8'h77, 1'b1);
        gap_req = 0;
        gap_len = 3;
        drive();
        run_until_idle(100, "gap");
        n_cmp += 2;
        if (grants.size() != 2 || grants[0] != 0 || grants[1] != 1) begin
            n_bad++; $display("FAIL gap_grants: got n=%0d first=%0d want 0 then 1", grants.size(), grants.size() > 0 ? grants[0] : -1);
        end
        if (blens.size() != 2 || blens[0] != 3) begin
            n_bad++; $display("FAIL gap_len: got n=%0d first=%0d want 3", blens.size(), blens.size() > 0 ? blens[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        do_reset();
        for (int k = 0; k < 3; k++) push_word(0, N'(8'h60 + k), k == 2);
        push_word(1, 8'h99, 1'b1);
        drive();
        while (!(holder == 0 && taken == 1) && c < 10) begin cycle(); c++; end
        n_cmp++;
        if (c >= 10) begin n_bad++; $display("FAIL midrst_reach: got %0d cycles want < 10", c); end
        rstn = 1'b0;
        #1;
        n_cmp += 3;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %0b want 0", busy); end
        if (p_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_p_valid: got %0b want 0", p_valid); end
        if (grant_id !== GW'(M - 1)) begin n_bad++; $display("FAIL midrst_grant_id: got %0d want %0d", grant_id, M - 1); end
        model_reset();
        grants.delete(); blens.delete(); acc_words.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive();
        run_until_idle(100, "midrst");
        n_cmp += 2;
        if (grants.size() < 1 || grants[0] != 0) begin
            n_bad++; $display("FAIL midrst_first: got %0d want 0", grants.size() > 0 ? grants[0] : -1);
        end
        if (acc_words.size() != 3 || acc_words[0] !== 8'h61) begin
            n_bad++; $display("FAIL midrst_words: got n=%0d want 3 starting 61", acc_words.size());
        end
    endtask

    task automatic test_random();
        int total, cnt;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            pr_mode = 1;
            rand_gaps = 1'b1;
            total = 0;
            for (int r = 0; r < M; r++) begin
                cnt = $urandom_range(0, 8);
                for (int k = 0; k < cnt; k++)
                    push_word(r, N'($urandom), (k == cnt - 1) || ($urandom_range(0, 3) == 0));
                total += cnt;
            end
            drive();
            run_until_idle(3000, "rand");
            n_cmp++;
            if (acc_words.size() != total) begin
                n_bad++; $display("FAIL rand_total[%0d]: got %0d want %0d", it, acc_words.size(), total);
            end
            foreach (blens[k]) begin
                n_cmp++;
                if (blens[k] < 1 || blens[k] > MB) begin
                    n_bad++; $display("FAIL rand_blen[%0d]: got %0d want 1..%0d", k, blens[k], MB);
                end
            end
        end
    endtask

    initial begin
        clear_all();
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_valid_gap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/p2s_arbiter.md
# p2s_arbiter

Shares one parallel-to-serial converter between M parallel word sources. Arbitrates among requesters with round-robin priority and holds the grant for a burst of words. Muxes the granted requester's valid/data onto the converter's parallel input and returns the converter's ready to that requester only. Sits between the word producers and the p2s serializer; the serializer's p_valid/p_ready/p_data handshake is the downstream interface.

## Interface
- N, default 8: word width in bits; matches the serializer's N.
- M, default 4: number of requesters, M ≥ 2.
- MAX_BURST, default 4: maximum words accepted per grant, ≥ 1.
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- req_valid  input  M  per-requester word valid.
- req_data  input  M*N  requester i's word is at bits [i*N +: N].
- req_last  input  M  marks the final word of requester i's burst.
- req_ready  output  M  one-hot or zero; word accepted from i when req_valid[i] && req_ready[i].
- p_valid  output  1  to serializer p_valid.
- p_data  output  N  to serializer p_data.
- p_ready  input  1  from serializer p_ready.
- busy  output  1  high while a grant is held.
- grant_id  output  $clog2(M)  index of the current or last granted requester.

## Operation
- States: IDLE, GRANT. Two-state registered FSM.
- IDLE:
  - p_valid=0, req_ready=0, busy=0.
  - If any req_valid is high, select the winner, register it into grant_id, clear the beat counter, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - p_valid = req_valid[grant_id].
  - p_data = req_data word grant_id.
  - req_ready[grant_id] = p_ready; all other req_ready bits are 0.
  - busy=1.
- Beat accepted: p_valid && p_ready in GRANT. On each accepted beat, the beat counter increments.
- Leave GRANT for IDLE on an accepted beat when req_last[grant_id]=1 or the beat counter = MAX_BURST-1. Otherwise stay in GRANT.
- Granted requester deasserts req_valid mid-burst: the grant is held, p_valid drops, and the arbiter waits indefinitely. There is no timeout and no preemption.
- Round-robin selection:
  - Search starts at index grant_id+1 (mod M) and wraps. The first requester found with req_valid=1 wins.
  - The requester just served therefore has lowest priority at the next arbitration.
- Beat counter width: $clog2(MAX_BURST), minimum 1 bit. It never wraps because GRANT exits at MAX_BURST-1.
- req_data/req_last of non-granted requesters are ignored. Changes to req_valid of other requesters during GRANT have no effect.
- Requester contract: once req_valid is high, it must not drop nor change req_data until accepted. The arbiter does not check this.

## Timing
- Reset values: state=IDLE, grant_id=M-1 (requester 0 has highest priority at the first arbitration), beat counter=0.
- Output reset values: p_valid=0, req_ready=0, busy=0, p_data=word M-1.
- Arbitration latency:
  - req_valid rises in cycle t while IDLE → GRANT and p_valid=1 in cycle t+1.
  - The first word can be accepted in t+1 if p_ready=1.
- p_valid, p_data and req_ready are combinational from registered state/grant_id and the granted requester's inputs. There is no added pipeline stage.
- Burst end: the beat ending GRANT is followed by exactly one IDLE cycle before the next grant, so back-to-back bursts have one dead cycle.
- Serializer interaction:
  - p_ready is low for N cycles while the serializer shifts out a word.
  - The arbiter holds p_valid/p_data stable through that interval.
- Reset mid-burst: immediately forces IDLE and the reset values above. A word not yet accepted is not transferred, and the requester re-arbitrates after reset release.

## Configuration
- P2S_ARB_FIXED_PRIO_EN defined: selection is fixed priority. The lowest index with req_valid=1 wins, regardless of grant_id. Everything else is unchanged.
- P2S_ARB_FIXED_PRIO_EN undefined (default): round-robin as specified above.

## Test plan
- Single requester: M=4, only req_valid[2]=1 with data 0xA5, req_last=1, p_ready=1 → grant_id=2 one cycle later. p_data=0xA5, req_ready=4'b0100 for one cycle, then back to IDLE.
- Round-robin fairness: all four req_valid held high, every word has req_last=1 → grants 0,1,2,3,0 in order, one IDLE cycle between them. With P2S_ARB_FIXED_PRIO_EN defined → grant 0 every time.
- Burst cap: MAX_BURST=4, requester 1 streams 6 words with req_last=0 → exactly 4 accepted, then IDLE. The requester re-arbitrates and sends the remaining 2 in a later grant.
- Backpressure: arbiter driving the real p2s serializer (N=8), requesters 0 and 3 send 0x81 and 0x3C → serial stream LSB-first 10000001 then 00111100. p_data is held stable while p_ready=0 for 8 cycles.
- Valid gap mid-burst: requester 0 drops req_valid for 3 cycles after its first word → busy stays 1, grant_id stays 0, requester 1 is not granted, and the burst completes on req_last.
- Reset mid-burst: rstn low during the second beat of a grant → next cycle busy=0, p_valid=0, grant_id=3. After release, requester 0 wins first.
